// File: rtl/izh_sweep_scheduler_pkg.sv
// Shared types for the Izhikevich sweep scheduler.
// Words are sign-magnitude fixed point: MSB is the sign, the rest is the
// magnitude with 16 fractional bits.
package izh_pkg;

    localparam int FX_W = 32;

    typedef logic [FX_W-1:0] fx_t;

    localparam fx_t FX_ZERO    = 32'h0000_0000;
    localparam fx_t FX_ONE     = 32'h0001_0000;
    localparam fx_t FX_NEG_ONE = 32'h8001_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPUTE,
        S_WRITE,
        S_SPIKE,
        S_DONE
    } state_t;

    // Signed a >= b on sign-magnitude words. A zero magnitude counts as
    // positive, so -0 and +0 compare equal.
    function automatic logic fx_ge(input fx_t a, input fx_t b);
        logic a_neg;
        logic b_neg;
        a_neg = a[FX_W-1] && (a[FX_W-2:0] != '0);
        b_neg = b[FX_W-1] && (b[FX_W-2:0] != '0);
        if (a_neg != b_neg) return b_neg;
        else if (a_neg)     return a[FX_W-2:0] <= b[FX_W-2:0];
        else                return a[FX_W-2:0] >= b[FX_W-2:0];
    endfunction

endpackage

// File: rtl/izh_sweep_scheduler_if.sv
// Bus between the sweep scheduler and the shared dv/dw datapath, plus the
// spike event handshake.
//   dp_v/dp_w/dp_i : operands to the datapath (scheduler drives)
//   dp_dv/dp_dw    : combinational datapath results (datapath drives)
//   spike_valid/spike_idx/spike_ready : spike event valid/ready channel
interface izh_sweep_scheduler_if #(
    parameter int N     = 32,
    parameter int IDX_W = 3
);
    logic [N-1:0]     dp_v;
    logic [N-1:0]     dp_w;
    logic [N-1:0]     dp_i;
    logic [N-1:0]     dp_dv;
    logic [N-1:0]     dp_dw;
    logic             spike_valid;
    logic [IDX_W-1:0] spike_idx;
    logic             spike_ready;

    modport master (
        output dp_v, dp_w, dp_i, spike_valid, spike_idx,
        input  dp_dv, dp_dw, spike_ready
    );

    modport slave (
        input  dp_v, dp_w, dp_i, spike_valid, spike_idx,
        output dp_dv, dp_dw, spike_ready
    );
endinterface

// File: rtl/add.sv
// Sign-magnitude adder used throughout the codebase.
//   a, b : N-bit sign-magnitude operands
//   y    : a + b; magnitude wraps on overflow, a zero result is always +0
module add #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);
    logic [N-2:0] mag;
    logic         sgn;

    always_comb begin
        mag = '0;
        sgn = 1'b0;
        if (a[N-1] == b[N-1]) begin
            mag = a[N-2:0] + b[N-2:0];
            sgn = a[N-1];
        end else if (a[N-2:0] >= b[N-2:0]) begin
            mag = a[N-2:0] - b[N-2:0];
            sgn = a[N-1];
        end else begin
            mag = b[N-2:0] - a[N-2:0];
            sgn = b[N-1];
        end
        if (mag == '0) sgn = 1'b0;
        y = {sgn, mag};
    end
endmodule

// File: rtl/izh_sweep_scheduler_state_regs.sv
// Per-neuron v/w/i register file.
//   rd_*      : combinational read port, used in FETCH
//   wr_*      : v/w write port, used in WRITE
//   cur_*     : input current write port, accepted at any time
// A current write and a read of the same neuron in one cycle returns the
// old current; the new one is visible from the next cycle.
module izh_state_regs
    import izh_pkg::*;
#(
    parameter int           N           = 32,
    parameter int           NUM_NEURONS = 8,
    parameter int           IDX_W       = 3,
    parameter logic [N-1:0] V_INIT      = 32'h8041_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [N-1:0]     rd_v,
    output logic [N-1:0]     rd_w,
    output logic [N-1:0]     rd_i,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [N-1:0]     wr_v,
    input  logic [N-1:0]     wr_w,
    input  logic             cur_we,
    input  logic [IDX_W-1:0] cur_idx,
    input  logic [N-1:0]     cur_data
);
    logic [NUM_NEURONS-1:0][N-1:0] v_q;
    logic [NUM_NEURONS-1:0][N-1:0] w_q;
    logic [NUM_NEURONS-1:0][N-1:0] i_q;

    assign rd_v = v_q[rd_idx];
    assign rd_w = w_q[rd_idx];
    assign rd_i = i_q[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_q[k] <= V_INIT;
                w_q[k] <= FX_ZERO;
                i_q[k] <= FX_ZERO;
            end
        end else begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (wr_en && wr_idx == IDX_W'(k)) begin
                    v_q[k] <= wr_v;
                    w_q[k] <= wr_w;
                end
                if (cur_we && cur_idx == IDX_W'(k)) i_q[k] <= cur_data;
            end
        end
    end
endmodule

// File: rtl/izh_sweep_scheduler.sv
// Time-multiplexed sequencer sharing one Izhikevich dv/dw datapath across
// NUM_NEURONS neurons. On start it sweeps every neuron once:
// FETCH -> COMPUTE -> WRITE (-> SPIKE) per neuron, then a DONE pulse.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin a sweep (only taken in IDLE)
//   step,c,d,v_th   : step size (used by the datapath), reset potential,
//                     recovery increment, spike threshold
//   cur_we/idx/data : input current write
//   busy, done      : sweep in progress / one-cycle completion pulse
//   bus             : datapath operands/results and spike handshake
module izh_sweep_scheduler
    import izh_pkg::*;
#(
    parameter int           N           = 32,
    parameter int           Q           = 16,
    parameter int           NUM_NEURONS = 8,
    parameter int           IDX_W       = $clog2(NUM_NEURONS),
    parameter logic [N-1:0] V_INIT      = 32'h8041_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     step,
    input  logic [N-1:0]     c,
    input  logic [N-1:0]     d,
    input  logic [N-1:0]     v_th,
    input  logic             cur_we,
    input  logic [IDX_W-1:0] cur_idx,
    input  logic [N-1:0]     cur_data,
    output logic             busy,
    output logic             done,
    izh_sweep_scheduler_if.master bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     rd_v, rd_w, rd_i;
    logic [N-1:0]     v_new, w_new, w_plus_d;
    logic [N-1:0]     v_new_q, w_new_q;
    logic [N-1:0]     wr_v, wr_w;
    logic             spk_q;
    logic             fetch_en, cmp_en, wr_en, advance;

    // step is consumed by the external datapath; Q only documents the format.
    logic unused_cfg;
    assign unused_cfg = ^{step, 32'(Q)};

    add #(.N(N)) u_add_v (.a(bus.dp_v), .b(bus.dp_dv), .y(v_new));
    add #(.N(N)) u_add_w (.a(bus.dp_w), .b(bus.dp_dw), .y(w_new));
    add #(.N(N)) u_add_d (.a(w_new_q),  .b(d),         .y(w_plus_d));

    // A spiking neuron is reset instead of taking the integrated v.
    assign wr_v = spk_q ? c        : v_new_q;
    assign wr_w = spk_q ? w_plus_d : w_new_q;

    izh_state_regs #(
        .N(N), .NUM_NEURONS(NUM_NEURONS), .IDX_W(IDX_W), .V_INIT(V_INIT)
    ) u_regs (
        .clk(clk), .rst_n(rst_n),
        .rd_idx(idx_q), .rd_v(rd_v), .rd_w(rd_w), .rd_i(rd_i),
        .wr_en(wr_en), .wr_idx(idx_q), .wr_v(wr_v), .wr_w(wr_w),
        .cur_we(cur_we), .cur_idx(cur_idx), .cur_data(cur_data)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fetch_en = 1'b0;
        cmp_en   = 1'b0;
        wr_en    = 1'b0;
        advance  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                idx_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                fetch_en = 1'b1;
                state_d  = S_COMPUTE;
            end
            S_COMPUTE: begin
                cmp_en  = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en = 1'b1;
                if (spk_q) state_d = S_SPIKE;
                else       advance = 1'b1;
            end
            S_SPIKE: if (bus.spike_ready) advance = 1'b1;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            if (idx_q == LAST) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dp_v        <= V_INIT;
            bus.dp_w        <= '0;
            bus.dp_i        <= '0;
            bus.spike_valid <= 1'b0;
            bus.spike_idx   <= '0;
            v_new_q         <= '0;
            w_new_q         <= '0;
            spk_q           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            if (fetch_en) begin
                bus.dp_v <= rd_v;
                bus.dp_w <= rd_w;
                bus.dp_i <= rd_i;
            end
            if (cmp_en) begin
                v_new_q <= v_new;
                w_new_q <= w_new;
                spk_q   <= fx_ge(v_new, v_th);
            end
            if (wr_en && spk_q) bus.spike_idx <= idx_q;
            // Outputs follow the next state so they line up with the state
            // they describe rather than lagging it by a cycle.
            bus.spike_valid <= (state_d == S_SPIKE);
            busy            <= state_d inside {S_FETCH, S_COMPUTE, S_WRITE, S_SPIKE};
            done            <= (state_d == S_DONE);
        end
    end
endmodule

// File: tb/tb_izh_sweep_scheduler.sv
module tb_izh_sweep_scheduler;
    import izh_pkg::*;

    localparam int          NN    = 8;
    localparam int          IW    = 3;
    localparam logic [31:0] VINIT = 32'h8041_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cur_we = 1'b0;
    logic [31:0]   step, c, d, v_th, cur_data;
    logic [IW-1:0] cur_idx;
    logic          busy, done;

    izh_sweep_scheduler_if #(.N(32), .IDX_W(IW)) bus ();

    izh_sweep_scheduler #(
        .N(32), .Q(16), .NUM_NEURONS(NN), .IDX_W(IW), .V_INIT(VINIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .c(c), .d(d),
        .v_th(v_th), .cur_we(cur_we), .cur_idx(cur_idx), .cur_data(cur_data),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Datapath stub: dv depends on the neuron's input current so one neuron
    // can be singled out; dw is always zero.
    logic [31:0] dv_base, dv_mark, mark_i;
    always_comb begin
        bus.dp_dv = (bus.dp_i == mark_i) ? dv_mark : dv_base;
        bus.dp_dw = '0;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model in plain signed integers.
    logic [31:0] m_v[NN], m_w[NN], m_i[NN];

    function automatic longint sm2int(input logic [31:0] x);
        return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    endfunction

    function automatic logic [31:0] int2sm(input longint x);
        return (x < 0) ? {1'b1, 31'(-x)} : {1'b0, 31'(x)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NN; k++) begin
            m_v[k] = VINIT;
            m_w[k] = '0;
            m_i[k] = '0;
        end
    endtask

    typedef struct { int cyc; int k; logic [31:0] v, w, i; } dp_exp_t;
    typedef struct { int cyc; int idx; } sp_exp_t;
    dp_exp_t dp_q[$];
    sp_exp_t sp_q[$];

    task automatic write_cur(input int k, input logic [31:0] val);
        @(negedge clk);
        cur_we = 1'b1; cur_idx = IW'(k); cur_data = val;
        @(negedge clk);
        cur_we = 1'b0;
        m_i[k] = val;
    endtask

    // One sweep. bp: ready-low cycles per spike; col_k: neuron whose current
    // is rewritten in its own FETCH cycle (-1 none); rst_at: cycle to pull
    // reset (0 none). Cycle 1 is the cycle after start is sampled.
    task automatic run_sweep(input int bp, input int col_k, input logic [31:0] col_data,
                             input int rst_at);
        int t, done_cyc, col_cyc, hold;
        bit in_spk;
        logic [31:0] dvk, vn;
        dp_exp_t e;
        t = 1; col_cyc = -1; hold = 0; in_spk = 0;
        for (int k = 0; k < NN; k++) begin
            dp_q.push_back('{t + 1, k, m_v[k], m_w[k], m_i[k]});
            if (k == col_k) col_cyc = t;
            dvk = (m_i[k] == mark_i) ? dv_mark : dv_base;
            vn  = int2sm(sm2int(m_v[k]) + sm2int(dvk));
            if (sm2int(vn) >= sm2int(v_th)) begin
                sp_q.push_back('{t + 3, k});
                m_v[k] = c;
                m_w[k] = int2sm(sm2int(m_w[k]) + sm2int(d));
                t += 4 + bp;
            end else begin
                m_v[k] = vn;
                t += 3;
            end
        end
        done_cyc = t;

        @(negedge clk);
        start = 1'b1;
        bus.spike_ready = (bp == 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= done_cyc + 2; cyc++) begin
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'(0));
                check("rst_spike_valid", 32'(bus.spike_valid), 32'(0));
                check("rst_done", 32'(done), 32'(0));
                check("rst_dp_v", bus.dp_v, VINIT);
                check("rst_dp_i", bus.dp_i, 32'h0);
                dp_q.delete();
                sp_q.delete();
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            cur_we = 1'b0;
            if (cyc == col_cyc) begin
                cur_we = 1'b1; cur_idx = IW'(col_k); cur_data = col_data;
            end
            // a start during the done pulse must be ignored
            start = (cyc == done_cyc);
            check("done", 32'(done), 32'(cyc == done_cyc));
            check("busy", 32'(busy), 32'(cyc < done_cyc));
            if (dp_q.size() > 0 && dp_q[0].cyc == cyc) begin
                e = dp_q.pop_front();
                check($sformatf("dp_v[%0d]", e.k), bus.dp_v, e.v);
                check($sformatf("dp_w[%0d]", e.k), bus.dp_w, e.w);
                check($sformatf("dp_i[%0d]", e.k), bus.dp_i, e.i);
            end
            if (bp > 0 && !bus.spike_valid) bus.spike_ready = 1'b0;
            if (bus.spike_valid) begin
                if (sp_q.size() == 0) begin
                    check("spike_unexpected", 32'(bus.spike_valid), 32'(0));
                end else begin
                    if (!in_spk) begin
                        check("spike_start_cyc", 32'(cyc), 32'(sp_q[0].cyc));
                        in_spk = 1;
                    end
                    check("spike_idx", 32'(bus.spike_idx), 32'(sp_q[0].idx));
                    if (!bus.spike_ready) begin
                        if (hold == bp) bus.spike_ready = 1'b1;
                        else hold++;
                    end
                    if (bus.spike_ready) begin
                        void'(sp_q.pop_front());
                        in_spk = 0;
                        hold = 0;
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        cur_we = 1'b0;
        check("dp_exp_left", 32'(dp_q.size()), 32'(0));
        check("spike_exp_left", 32'(sp_q.size()), 32'(0));
        if (col_k >= 0) m_i[col_k] = col_data;
    endtask

    initial begin
        step = FX_ONE; c = 32'h8041_0000; d = 32'h0008_0000; v_th = 32'h001E_0000;
        dv_base = '0; dv_mark = '0; mark_i = 32'h0000_0003;
        cur_idx = '0; cur_data = '0;
        bus.spike_ready = 1'b1;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        check("reset_dp_v", bus.dp_v, VINIT);
        check("reset_dp_w", bus.dp_w, 32'h0);
        check("reset_dp_i", bus.dp_i, 32'h0);
        check("reset_spike_valid", 32'(bus.spike_valid), 32'(0));
        check("reset_spike_idx", 32'(bus.spike_idx), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // idle sweep, no spikes, done at 25
        run_sweep(0, -1, '0, 0);

        // +1.0 per sweep: -64 then -63, observed through dp_v
        dv_base = FX_ONE;
        run_sweep(0, -1, '0, 0);
        run_sweep(0, -1, '0, 0);
        dv_base = '0;
        run_sweep(0, -1, '0, 0);

        // neuron 3 spikes, ready already high
        write_cur(3, mark_i);
        dv_mark = 32'h0064_0000;
        run_sweep(0, -1, '0, 0);
        // neuron 3 spikes again under 5 cycles of backpressure
        run_sweep(5, -1, '0, 0);
        dv_mark = '0;
        run_sweep(0, -1, '0, 0);

        // current write colliding with the same neuron's FETCH
        run_sweep(0, 2, 32'h0005_0000, 0);
        run_sweep(0, -1, '0, 0);

        // v_new equal to threshold spikes (neuron 3 lands exactly on -64)
        v_th = 32'h8040_0000; dv_base = FX_ONE; dv_mark = FX_ONE;
        run_sweep(0, -1, '0, 0);
        // +0 result against a -0 threshold spikes
        v_th = 32'h8000_0000; dv_base = 32'h0041_0000; dv_mark = 32'h0041_0000;
        run_sweep(0, -1, '0, 0);
        // +0 result just below a tiny positive threshold does not spike
        v_th = 32'h0000_0001; dv_base = 32'h0041_0000; dv_mark = FX_NEG_ONE;
        run_sweep(0, -1, '0, 0);

        // reset during neuron 5's COMPUTE, then a full clean sweep
        v_th = 32'h001E_0000; dv_base = '0; dv_mark = '0;
        run_sweep(0, -1, '0, 17);
        run_sweep(0, -1, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/izh_sweep_scheduler.md
# izh_sweep_scheduler

Time-multiplexed sequencer that shares one Izhikevich update datapath (the combinational dv/dw calculators) across `NUM_NEURONS` neurons. It holds per-neuron state (v, w, input current) and sweeps all neurons once per simulation timestep on `start`. For each neuron it drives operands to the shared datapath, commits v/w, detects threshold crossings, applies the spike reset (v←c, w←w+d) and emits spike events over a valid/ready handshake. Arithmetic is the codebase's N-bit sign-magnitude fixed point with Q fractional bits: MSB is the sign, the remaining bits are magnitude.

## Interface
- `N`, 32, word width.
- `Q`, 16, fractional bits.
- `NUM_NEURONS`, 8, neurons served (≥2).
- `IDX_W`, `$clog2(NUM_NEURONS)`, index width.
- `V_INIT`, `32'h8041_0000` (−65.0), reset value of every v.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin one sweep; ignored while `busy`.
- `step`, `c`, `d`, `v_th` in N each: step size, reset potential, recovery increment and spike threshold; sampled every cycle.
- `cur_we` in 1, `cur_idx` in IDX_W, `cur_data` in N: write the input current of neuron `cur_idx`.
- `dp_v`, `dp_w`, `dp_i` out N each: registered operands to the shared datapath.
- `dp_dv`, `dp_dw` in N each: combinational datapath results, already scaled by `step`.
- `spike_valid` out 1, `spike_idx` out IDX_W, `spike_ready` in 1: spike event handshake.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when a sweep completes.

## Operation
- FSM states: IDLE, FETCH, COMPUTE, WRITE, SPIKE, DONE.
- IDLE: an accepted `start` clears the neuron index to 0 and moves to FETCH.
- FETCH: register v[idx], w[idx] and i[idx] into `dp_v`, `dp_w` and `dp_i`, then go to COMPUTE.
- COMPUTE: sample `dp_dv` and `dp_dw`. Compute v_new = dp_v + dp_dv and w_new = dp_w + dp_dw using the codebase adder. Compare v_new ≥ `v_th` as a signed sign-magnitude comparison; +0 and −0 compare equal. Then go to WRITE.
- WRITE, no spike: commit v_new and w_new.
- WRITE, spike: commit v←`c` and w←w_new + `d`, assert `spike_valid` with `spike_idx`=idx, and go to SPIKE.
- SPIKE: hold `spike_valid` and `spike_idx` stable until `spike_ready`. The transfer completes in a cycle where both are high.
- After WRITE with no spike, or after a completed spike transfer: if idx = NUM_NEURONS−1 go to DONE, else idx+1 and go to FETCH.
- DONE: pulse `done`, drop `busy`, return to IDLE.
- Current writes are accepted in every state and take effect on the next cycle. A FETCH of the same neuron in the same cycle reads the old value.
- Overflow in the adder follows the adder's own behaviour; this block adds no saturation.
- Reset, including in the middle of a sweep: state → IDLE, idx=0, all v=`V_INIT`, all w=0, all i=0, and all outputs 0 except as listed here. The in-flight neuron is discarded and any pending spike is dropped.

## Timing
- Reset values: `dp_v`=`V_INIT`, `dp_w`=0, `dp_i`=0, `spike_valid`=0, `spike_idx`=0, `busy`=0, `done`=0.
- With no backpressure, each neuron takes 3 cycles (FETCH, COMPUTE, WRITE).
- A sweep takes 3·NUM_NEURONS cycles plus 1 DONE cycle. `done` pulses 3·NUM_NEURONS+1 cycles after the `start` cycle, i.e. 25 cycles for 8 neurons.
- A spike adds ≥1 SPIKE cycle per spiking neuron. If `spike_ready` is already high, SPIKE lasts exactly 1 cycle.
- `start` asserted in the same cycle as `done` is ignored. The earliest accepted restart is the cycle after `done`.
- The datapath must settle within one cycle, since `dp_*` is registered in FETCH and sampled in COMPUTE.

## Structure
- Package `izh_pkg` holds:
  - the fixed-point typedef `fx_t` (logic [N-1:0]);
  - constants `FX_ZERO`, `FX_ONE`=`32'h0001_0000` and `FX_NEG_ONE`=`32'h8001_0000`;
  - function `fx_ge(a,b)` for sign-magnitude comparison;
  - the state enum.
- Sub-module `izh_state_regs` is the per-neuron v/w/i register file. It has one read port (FETCH), one v/w write port (WRITE) and one current write port, with asynchronous active-low reset to the init values.
- The two update adders instantiate the existing `add` module. The w+d adder is a third `add` instance.

## Test plan
- **Reset/init:** release `rst_n`, stub dv=0, dw=0, one sweep → no spikes; `done` 25 cycles after `start`; all `dp_v` seen equal `32'h8041_0000`.
- **Plain integration:** stub dv=`32'h0001_0000` (+1.0), dw=0 → after one sweep every v = −64.0 (`32'h8040_0000`); after two sweeps v = −63.0.
- **Spike and reset:** neuron 3 only gets dv=+100.0 (`32'h0064_0000`), with v_th=30.0, c=−65.0, d=8.0 → v_new = 35.0, so `spike_idx`=3. Then v[3]=`32'h8041_0000` and w[3]=`32'h0008_0000`; the other neurons are unchanged.
- **Backpressure:** as the spike test, with `spike_ready` low for 5 cycles → `spike_valid`/`spike_idx` stable throughout; neuron 4's FETCH is delayed by exactly 5 cycles; `done` at cycle 31.
- **Current-write collision:** write `cur_idx`=2 with 5.0 in neuron 2's FETCH cycle → `dp_i` shows the old value this sweep and 5.0 the next sweep.
- **Mid-sweep reset:** assert `rst_n` low during neuron 5's COMPUTE → `busy`=0, `spike_valid`=0, v=`V_INIT` for all neurons; a new `start` runs a full 25-cycle sweep.
